// File: rtl/bit8_bus_arbiter.sv
// bit8_bus_arbiter: two-requester round-robin arbiter with bounded bursts.
// One 8-bit 2:1 mux selects the granted byte into a registered output.

// 8-bit 2:1 multiplexer: y = a when sel=0, b when sel=1
module bit8_mux2 (
   input  logic       sel,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);
   assign y = sel ? b : a;
endmodule

module bit8_bus_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       sel,
   output logic [7:0] out,
   output logic       out_valid
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             last;
   logic             last_nxt;
   logic             beat_c;
   logic             own1_c;
   logic             oth_req_c;
   logic [7:0]       mux_y;

   // Grants and select decode directly from the state register
   assign gnt0 = (state == OWN0);
   assign gnt1 = (state == OWN1);
   assign sel  = gnt1;

   // A beat is a granted cycle whose owner is still requesting
   assign beat_c    = (gnt0 && req0) || (gnt1 && req1);
   assign own1_c    = gnt1;
   assign oth_req_c = own1_c ? req0 : req1;

   bit8_mux2 u_mux (
      .sel (sel),
      .a   (in0),
      .b   (in1),
      .y   (mux_y)
   );

   // State, burst counter and last-granted registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
      end
   end

   // Next-state: tie-break on last, bounded bursts, zero-bubble handover
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last)) begin
               state_nxt = OWN0;
               cnt_nxt   = '0;
               last_nxt  = 1'b0;
            end else if (req1) begin
               state_nxt = OWN1;
               cnt_nxt   = '0;
               last_nxt  = 1'b1;
            end
         end
         OWN0, OWN1: begin
            if (beat_c && (cnt < CNT_LAST)) begin
               cnt_nxt = cnt + CNT_W'(1);
            end else if (oth_req_c) begin
               state_nxt = own1_c ? OWN0 : OWN1;
               cnt_nxt   = '0;
               last_nxt  = !own1_c;
            end else if (beat_c) begin
               cnt_nxt = '0;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output register: capture the selected byte on every beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out       <= 8'h00;
         out_valid <= 1'b0;
      end else begin
         out_valid <= beat_c;
         if (beat_c) begin
            out <= mux_y;
         end
      end
   end

endmodule
